// File: rtl/gate_array_pkg.sv
// Shared definitions for the parametrised gate package model.
//   FUNC_*       : logic function selectors for gate_array_n / gate_channel
//   MAX_INPUTS   : widest gate supported (inputs per gate)
//   MAX_DELAY    : longest gate latency in clk cycles
//   gate_eval()  : evaluates one gate over the low n bits of 'bits'
package gate_array_pkg;

  localparam int unsigned FUNC_NOR  = 0;
  localparam int unsigned FUNC_NAND = 1;
  localparam int unsigned FUNC_OR   = 2;
  localparam int unsigned FUNC_AND  = 3;
  localparam int unsigned FUNC_XOR  = 4;
  localparam int unsigned FUNC_XNOR = 5;

  localparam int unsigned MAX_INPUTS  = 8;
  localparam int unsigned MAX_DELAY   = 15;
  localparam int unsigned MAX_CHANNELS = 16;

  // Bits at or above n are masked off so callers may zero-extend freely.
  function automatic logic gate_eval(input int unsigned func,
                                     input logic [MAX_INPUTS-1:0] bits,
                                     input int unsigned n);
    logic [MAX_INPUTS-1:0] mask;
    logic                  all_ones;
    logic                  any_one;
    logic                  parity;
    logic                  res;
    mask     = {MAX_INPUTS{1'b1}} >> (MAX_INPUTS - n);
    all_ones = &(bits | ~mask);
    any_one  = |(bits & mask);
    parity   = ^(bits & mask);
    case (func)
      FUNC_NOR:  res = ~any_one;
      FUNC_NAND: res = ~all_ones;
      FUNC_OR:   res = any_one;
      FUNC_AND:  res = all_ones;
      FUNC_XOR:  res = parity;
      FUNC_XNOR: res = ~parity;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_channel.sv
// One gate of the package: logic function, clocked delay (transport pipeline
// or inertial filter), change strobe and sticky glitch flag.
//   clk, rst   : clock, asynchronous active-low reset
//   a          : this gate's INPUTS input bits
//   clr_flags  : synchronous clear of glitch (a same-edge swallow wins)
//   y          : gate output, forced to IC_BIT during reset
//   y_chg      : high for the cycle after an edge at which y toggled
//   glitch     : sticky, inertial filter swallowed a pulse
module gate_channel
  import gate_array_pkg::*;
#(
  parameter int unsigned FUNC         = FUNC_NOR,
  parameter int unsigned INPUTS       = 2,
  parameter int unsigned DELAY_CYCLES = 1,
  parameter int unsigned INERTIAL     = 0,
  parameter logic        IC_BIT       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INPUTS-1:0] a,
  input  logic              clr_flags,
  output logic              y,
  output logic              y_chg,
  output logic              glitch
);

  logic f_c;
  logic y_nxt_c;
  logic glitch_set_c;

  assign f_c = gate_eval(FUNC, MAX_INPUTS'(a), INPUTS);

  if (INERTIAL == 0 && DELAY_CYCLES > 1) begin : g_transport
    // Stages ahead of y; the output flop itself is the last stage.
    logic [DELAY_CYCLES-2:0] pipe;
    logic [DELAY_CYCLES-1:0] line_c;

    assign line_c       = {pipe, f_c};
    assign y_nxt_c      = line_c[DELAY_CYCLES-1];
    assign glitch_set_c = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe <= {(DELAY_CYCLES-1){IC_BIT}};
      end else begin
        pipe <= line_c[DELAY_CYCLES-2:0];
      end
    end
  end else if (INERTIAL != 0 && DELAY_CYCLES > 1) begin : g_inertial
    localparam int unsigned    CNT_W    = $clog2(DELAY_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;

    // Count consecutive edges with f != y; a run that ends early is a glitch.
    always_comb begin
      cnt_nxt_c    = '0;
      y_nxt_c      = y;
      glitch_set_c = 1'b0;
      if (f_c == y) begin
        glitch_set_c = (cnt != '0);
      end else if (cnt == CNT_LAST) begin
        y_nxt_c = f_c;
      end else begin
        cnt_nxt_c = cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_nxt_c;
      end
    end
  end else begin : g_direct
    // Single-cycle latency: both modes collapse to one register.
    assign y_nxt_c      = f_c;
    assign glitch_set_c = 1'b0;
  end

  // Output, change strobe and sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y      <= IC_BIT;
      y_chg  <= 1'b0;
      glitch <= 1'b0;
    end else begin
      y      <= y_nxt_c;
      y_chg  <= y_nxt_c ^ y;
      glitch <= glitch_set_c | (glitch & ~clr_flags);
    end
  end

endmodule

// File: rtl/gate_array_n.sv
// Package of CHANNELS identical K-input gates with clocked delay.
//   clk, rst   : clock, asynchronous active-low reset
//   vcc, gnd   : power pins, present for pin-compatible wiring only
//   a          : gate inputs, channel i on a[i*INPUTS +: INPUTS]
//   clr_flags  : synchronous clear of all glitch flags
//   y          : gate outputs (IC during reset)
//   y_chg      : per-channel one-cycle change strobe
//   glitch     : per-channel sticky swallowed-pulse flag
module gate_array_n
  import gate_array_pkg::*;
#(
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         INPUTS       = 2,
  parameter int unsigned         FUNC         = FUNC_NOR,
  parameter int unsigned         DELAY_CYCLES = 1,
  parameter int unsigned         INERTIAL     = 0,
  parameter logic [CHANNELS-1:0] IC           = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vcc,
  input  logic                         gnd,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  input  logic                         clr_flags,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          y_chg,
  output logic [CHANNELS-1:0]          glitch
);

  // Power pins carry no function.
  logic unused_pins;
  assign unused_pins = vcc ^ gnd;

  // Parameter legality.
  if (CHANNELS == 0 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("gate_array_n: CHANNELS=%0d outside 1..%0d", CHANNELS, MAX_CHANNELS);
  end
  if (INPUTS == 0 || INPUTS > MAX_INPUTS) begin : g_bad_inputs
    $error("gate_array_n: INPUTS=%0d outside 1..%0d", INPUTS, MAX_INPUTS);
  end
  if (FUNC > FUNC_XNOR) begin : g_bad_func
    $error("gate_array_n: FUNC=%0d is not a legal gate function", FUNC);
  end
  if (DELAY_CYCLES == 0 || DELAY_CYCLES > MAX_DELAY) begin : g_bad_delay
    $error("gate_array_n: DELAY_CYCLES=%0d outside 1..%0d", DELAY_CYCLES, MAX_DELAY);
  end
  if (INERTIAL > 1) begin : g_bad_inertial
    $error("gate_array_n: INERTIAL=%0d must be 0 or 1", INERTIAL);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gate_channel #(
      .FUNC         (FUNC),
      .INPUTS       (INPUTS),
      .DELAY_CYCLES (DELAY_CYCLES),
      .INERTIAL     (INERTIAL),
      .IC_BIT       (IC[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a         (a[i*INPUTS +: INPUTS]),
      .clr_flags (clr_flags),
      .y         (y[i]),
      .y_chg     (y_chg[i]),
      .glitch    (glitch[i])
    );
  end

endmodule

// File: tb/tb_gate_array_n.sv
// Bench for gate_array_n: several configurations share one stimulus bus; a
// reference model (history of gate values since reset) predicts every output
// and a scoreboard monitor compares after each rising edge.
module tb_gate_array_n;

  localparam int NI = 11;
  localparam int unsigned CFG_CH [NI] = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8, 3};
  localparam int unsigned CFG_IN [NI] = '{2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 1};
  localparam int unsigned CFG_FN [NI] = '{0, 3, 3, 4, 0, 1, 2, 3, 4, 5, 0};
  localparam int unsigned CFG_DL [NI] = '{1, 3, 3, 4, 2, 2, 2, 2, 2, 2, 5};
  localparam int unsigned CFG_IR [NI] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  localparam logic [15:0] CFG_IC [NI] = '{16'hA, 16'h0, 16'h0, 16'h6, 16'h0, 16'h0,
                                         16'h0, 16'h0, 16'h0, 16'h0, 16'h5};

  typedef struct packed {
    logic [NI-1:0][7:0] y;
    logic [NI-1:0][7:0] c;
    logic [NI-1:0][7:0] g;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr_flags;
  logic [23:0] stim;
  logic [7:0]  y_o [NI];
  logic [7:0]  c_o [NI];
  logic [7:0]  g_o [NI];

  int total = 0;
  int bad   = 0;

  exp_t        sb_q [$];
  logic [7:0]  hist [NI][$];
  logic [7:0]  y_m  [NI];
  logic [7:0]  g_m  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int unsigned CH  = CFG_CH[k];
    localparam int unsigned IN  = CFG_IN[k];
    localparam logic [15:0] ICW = CFG_IC[k];
    logic [CH-1:0] y;
    logic [CH-1:0] y_chg;
    logic [CH-1:0] glitch;

    gate_array_n #(
      .CHANNELS     (CH),
      .INPUTS       (IN),
      .FUNC         (CFG_FN[k]),
      .DELAY_CYCLES (CFG_DL[k]),
      .INERTIAL     (CFG_IR[k]),
      .IC           (ICW[CH-1:0])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .vcc       (1'b1),
      .gnd       (1'b0),
      .a         (stim[CH*IN-1:0]),
      .clr_flags (clr_flags),
      .y         (y),
      .y_chg     (y_chg),
      .glitch    (glitch)
    );

    assign y_o[k] = 8'(y);
    assign c_o[k] = 8'(y_chg);
    assign g_o[k] = 8'(glitch);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int k, input logic [7:0] act,
                       input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, k, $time, act, want);
    end
  endtask

  // Gate truth value per channel from the count of ones among its inputs.
  function automatic logic [7:0] ref_eval(input int k, input logic [23:0] s);
    logic [7:0]  r;
    logic [23:0] sh;
    int          ones;
    r = '0;
    for (int c = 0; c < CFG_CH[k]; c++) begin
      sh   = s >> (c * CFG_IN[k]);
      ones = $countones(sh & ((24'd1 << CFG_IN[k]) - 24'd1));
      case (CFG_FN[k])
        0:       r[c] = (ones == 0);
        1:       r[c] = (ones != int'(CFG_IN[k]));
        2:       r[c] = (ones != 0);
        3:       r[c] = (ones == int'(CFG_IN[k]));
        4:       r[c] = (ones % 2 == 1);
        default: r[c] = (ones % 2 == 0);
      endcase
    end
    return r;
  endfunction

  // Predict the state after the coming edge from the inputs just driven.
  task automatic model_step();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      logic [7:0] yn;
      logic [7:0] gn;
      logic [7:0] gs;
      logic [7:0] fv;
      int         n;
      int         d;
      logic       all_diff;
      d = int'(CFG_DL[k]);
      if (!rst) begin
        hist[k].delete();
        yn = CFG_IC[k][7:0];
        gn = '0;
        e.c[k] = '0;
      end else begin
        fv = ref_eval(k, stim);
        hist[k].push_back(fv);
        if (hist[k].size() > 32) void'(hist[k].pop_front());
        n  = hist[k].size();
        yn = y_m[k];
        gs = '0;
        for (int c = 0; c < int'(CFG_CH[k]); c++) begin
          if (CFG_IR[k] == 0) begin
            yn[c] = (n >= d) ? hist[k][n-d][c] : CFG_IC[k][c];
          end else begin
            // Follow only after d consecutive samples disagreeing with y.
            all_diff = (n >= d);
            if (all_diff) begin
              for (int j = 1; j <= d; j++)
                if (hist[k][n-j][c] == y_m[k][c]) all_diff = 1'b0;
            end
            if (all_diff) yn[c] = ~y_m[k][c];
            // A disagreement run that ended before completing was swallowed.
            if (fv[c] == y_m[k][c] && n >= 2 && hist[k][n-2][c] != y_m[k][c])
              gs[c] = 1'b1;
          end
        end
        gn = gs | (g_m[k] & ~{8{clr_flags}});
        e.c[k] = yn ^ y_m[k];
      end
      e.y[k] = yn;
      e.g[k] = gn;
      y_m[k] = yn;
      g_m[k] = gn;
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [23:0] s, input logic c);
    @(negedge clk);
    rst       = r;
    stim      = s;
    clr_flags = c;
    model_step();
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < NI; k++) begin
          check("sb_y", k, y_o[k], e.y[k]);
          check("sb_chg", k, c_o[k], e.c[k]);
          check("sb_glitch", k, g_o[k], e.g[k]);
        end
      end
    end
  end

  initial begin
    logic [23:0] s;
    int          hold;
    rst       = 1'b1;
    clr_flags = 1'b0;
    stim      = '0;
    for (int k = 0; k < NI; k++) begin
      y_m[k] = CFG_IC[k][7:0];
      g_m[k] = '0;
    end

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_y", k, y_o[k], CFG_IC[k][7:0]);
      check("rst_chg", k, c_o[k], 8'h00);
      check("rst_glitch", k, g_o[k], 8'h00);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Release: NOR of zeros drives all ones one edge later.
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("rel_y", 0, y_o[0], 8'h0F);
    check("rel_chg", 0, c_o[0], 8'h05);
    step(1'b1, '0, 1'b0);
    check("rel_chg_off", 0, c_o[0], 8'h00);
    repeat (8) step(1'b1, '0, 1'b0);

    // One-cycle pulse on channel 0: transport reproduces it, inertial swallows.
    step(1'b1, 24'h3, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("tr_pulse_hi", 1, 8'(y_o[1][0]), 8'd1);
    step(1'b1, '0, 1'b0);
    check("tr_pulse_lo", 1, 8'(y_o[1][0]), 8'd0);
    repeat (4) step(1'b1, '0, 1'b0);

    // Two-cycle pulse swallowed by the inertial gate.
    repeat (2) step(1'b1, 24'h3, 1'b0);
    repeat (6) step(1'b1, '0, 1'b0);
    check("in_swallow_y", 2, 8'(y_o[2][0]), 8'd0);
    check("in_swallow_g", 2, 8'(g_o[2][0]), 8'd1);

    // Three-cycle pulse passes.
    repeat (3) step(1'b1, 24'h3, 1'b0);
    step(1'b1, '0, 1'b0);
    check("in_pass_hi", 2, 8'(y_o[2][0]), 8'd1);
    repeat (6) step(1'b1, '0, 1'b0);

    // Glitch on channel 2, then clear racing a new swallow, then clear alone.
    step(1'b1, 24'h30, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("race_pre", 2, 8'(g_o[2][2]), 8'd1);
    step(1'b1, 24'h30, 1'b0);
    step(1'b1, '0, 1'b1);
    step(1'b1, '0, 1'b0);
    check("race_set_wins", 2, 8'(g_o[2][2]), 8'd1);
    step(1'b1, '0, 1'b1);
    step(1'b1, '0, 1'b0);
    check("clr_alone", 2, 8'(g_o[2][2]), 8'd0);

    // Every 3-bit code on every function.
    for (int code = 0; code < 8; code++) begin
      for (int c = 0; c < 8; c++) s[c*3 +: 3] = 3'((code + c) % 8);
      repeat (3) step(1'b1, s, 1'b0);
    end

    // Random inputs with random hold times and occasional flag clears.
    for (int i = 0; i < 120; i++) begin
      s    = 24'($urandom);
      hold = int'($urandom_range(1, 6));
      for (int h = 0; h < hold; h++)
        step(1'b1, s, ($urandom_range(15) == 0));
    end

    // Pulse in flight through the 4-deep transport gate when reset hits.
    repeat (8) step(1'b1, '0, 1'b0);
    step(1'b1, 24'h1, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    #1;
    check("midrst_snap", 3, y_o[3], 8'h06);
    check("midrst_chg", 3, c_o[3], 8'h00);
    step(1'b1, '0, 1'b0);
    repeat (8) step(1'b1, '0, 1'b0);
    check("midrst_settle", 3, y_o[3], 8'h00);

    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
